// File: rtl/mips_branch_pkg.sv
// Shared definitions for the ID-stage branch controller.
//   FWD_RF / FWD_MEM_ALU / FWD_MEM_LD : comparator operand select codes
//                                       (2'b11 is reserved and never driven)
//   state_e                           : branch FSM state encoding
package mips_branch_pkg;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_MEM_ALU = 2'b01;
  localparam logic [1:0] FWD_MEM_LD  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/branch_hazard_detect.sv
// Per-operand hazard and forwarding decision for the ID-stage comparator.
// Ports:
//   src_i                          : operand register specifier
//   ex_wreg_i, ex_m2reg_i, ex_rd_i : EX-stage writer (write enable, is-load, dest)
//   mem_wreg_i, mem_m2reg_i, mem_rd_i : MEM-stage writer
//   hazard_o                       : operand value is not yet obtainable in ID
//   fwd_o                          : comparator mux select for this operand
module branch_hazard_detect
  import mips_branch_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             ex_wreg_i,
  input  logic             ex_m2reg_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             mem_wreg_i,
  input  logic             mem_m2reg_i,
  input  logic [REG_W-1:0] mem_rd_i,
  output logic             hazard_o,
  output logic [1:0]       fwd_o
);

  logic exMatch;
  logic memMatch;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign exMatch  = ex_wreg_i  && (ex_rd_i  != '0) && (ex_rd_i  == src_i);
  assign memMatch = mem_wreg_i && (mem_rd_i != '0) && (mem_rd_i == src_i);

  // EX results are never forwarded into ID: a load or an ALU op in EX both
  // stall, and an EX match shadows any older MEM write to the same register.
  always_comb begin
    hazard_o = (exMatch && ex_m2reg_i) || (exMatch && !ex_m2reg_i);
    fwd_o    = FWD_RF;
    if (!exMatch && memMatch) begin
      fwd_o = mem_m2reg_i ? FWD_MEM_LD : FWD_MEM_ALU;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Control-hazard controller for beq/bne resolved in ID.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_valid, id_beq, id_bne : ID instruction valid and decoded branch type
//   id_rs, id_rt             : branch source registers
//   ex_* / mem_*             : EX and MEM writer info (wreg, m2reg, rd)
//   cmp_zero                 : comparator says operands are equal
//   fwd_a, fwd_b             : comparator operand selects
//   stall                    : freeze PC and IF/ID, bubble ID/EX
//   pc_sel, flush            : redirect to target / squash instruction entering IF/ID
//   br_cnt, taken_cnt, stall_cnt : saturating performance counters
// Build option: define BRANCH_DELAY_SLOT_EN to keep flush at 0 so the
// instruction after the branch always executes.
module branch_ctrl
  import mips_branch_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             cmp_zero,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             pc_sel,
  output logic             flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] brCnt_q, takenCnt_q, stallCnt_q;
  logic             hazardA, hazardB;
  logic [1:0]       fwdA, fwdB;
  logic             branchPresent;
  logic             resolve;
  logic             taken;

  branch_hazard_detect #(.REG_W(REG_W)) u_detect_a (
    .src_i      (id_rs),
    .ex_wreg_i  (ex_wreg),
    .ex_m2reg_i (ex_m2reg),
    .ex_rd_i    (ex_rd),
    .mem_wreg_i (mem_wreg),
    .mem_m2reg_i(mem_m2reg),
    .mem_rd_i   (mem_rd),
    .hazard_o   (hazardA),
    .fwd_o      (fwdA)
  );

  branch_hazard_detect #(.REG_W(REG_W)) u_detect_b (
    .src_i      (id_rt),
    .ex_wreg_i  (ex_wreg),
    .ex_m2reg_i (ex_m2reg),
    .ex_rd_i    (ex_rd),
    .mem_wreg_i (mem_wreg),
    .mem_m2reg_i(mem_m2reg),
    .mem_rd_i   (mem_rd),
    .hazard_o   (hazardB),
    .fwd_o      (fwdB)
  );

  // Outputs are combinational so the redirect happens in the same cycle the
  // operands become valid; everything is forced quiet while in reset.
  // A branch that drops id_valid while waiting simply stops being present,
  // which returns the FSM to IDLE without resolving or counting.
  always_comb begin
    branchPresent = id_valid && (id_beq || id_bne);
    taken         = id_beq ? cmp_zero : !cmp_zero;
    stall         = 1'b0;
    resolve       = 1'b0;
    state_d       = IDLE;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (branchPresent && (hazardA || hazardB)) begin
            stall   = 1'b1;
            state_d = WAIT;
          end else if (branchPresent) begin
            resolve = 1'b1;
          end
        end
        WAIT: begin
          if (!branchPresent) begin
            state_d = IDLE;
          end else if (hazardA || hazardB) begin
            stall   = 1'b1;
            state_d = WAIT;
          end else begin
            resolve = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    pc_sel = resolve && taken;
`ifdef BRANCH_DELAY_SLOT_EN
    flush  = 1'b0;
`else
    flush  = resolve && taken;
`endif
    fwd_a  = rst ? FWD_RF : fwdA;
    fwd_b  = rst ? FWD_RF : fwdB;
  end

  // State and saturating counters; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      brCnt_q    <= '0;
      takenCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (resolve && (brCnt_q != '1)) begin
        brCnt_q <= brCnt_q + CNT_ONE;
      end
      if (resolve && taken && (takenCnt_q != '1)) begin
        takenCnt_q <= takenCnt_q + CNT_ONE;
      end
      if (stall && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + CNT_ONE;
      end
    end
  end

  assign br_cnt    = brCnt_q;
  assign taken_cnt = takenCnt_q;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl (CNT_W=4 so saturation is reachable).
// Expected snapshots are queued as stimulus is applied; a negedge monitor
// queues observed snapshots, and each test task drains and compares them.
module tb_branch_ctrl;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  typedef struct packed {
    logic       stall;
    logic       pcSel;
    logic       flush;
    logic [1:0] fwdA;
    logic [1:0] fwdB;
    logic [3:0] br;
    logic [3:0] tk;
    logic [3:0] sc;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_beq, id_bne, cmp_zero;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, pc_sel, flush;
  logic [3:0] br_cnt, taken_cnt, stall_cnt;

  snap_t expQ[$];
  snap_t obsQ[$];
  int    reqCount = 0;
  int    servedCount = 0;
  int    checkCount = 0;
  int    passCount = 0;
  logic [3:0] mBr = 0, mTk = 0, mSc = 0;

  branch_ctrl #(.CNT_W(4), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_beq(id_beq), .id_bne(id_bne),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rd(mem_rd),
    .cmp_zero(cmp_zero),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .pc_sel(pc_sel), .flush(flush),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: one observed snapshot per requested cycle, away from the edge.
  always @(negedge clk) begin
    if (reqCount > servedCount) begin
      obsQ.push_back({stall, pc_sel, flush, fwd_a, fwd_b, br_cnt, taken_cnt, stall_cnt});
      servedCount++;
    end
  end

  task automatic set_br(input logic v, input logic beq, input logic bne,
                        input logic [4:0] rs, input logic [4:0] rt, input logic cz);
    id_valid = v; id_beq = beq; id_bne = bne; id_rs = rs; id_rt = rt; cmp_zero = cz;
  endtask

  task automatic set_ex(input logic w, input logic m, input logic [4:0] rd);
    ex_wreg = w; ex_m2reg = m; ex_rd = rd;
  endtask

  task automatic set_mem(input logic w, input logic m, input logic [4:0] rd);
    mem_wreg = w; mem_m2reg = m; mem_rd = rd;
  endtask

  // Queue the expected outputs for the cycle just driven, advance the
  // counter model, then move to just after the next rising edge.
  task automatic expect_cycle(input logic s, input logic res, input logic tk,
                              input logic [1:0] fa, input logic [1:0] fb);
    snap_t e;
    e.stall = s;
    e.pcSel = res & tk;
    e.flush = DelaySlot ? 1'b0 : (res & tk);
    e.fwdA  = fa;
    e.fwdB  = fb;
    e.br    = mBr;
    e.tk    = mTk;
    e.sc    = mSc;
    expQ.push_back(e);
    if (rst) begin
      mBr = 0; mTk = 0; mSc = 0;
    end else begin
      if (s && mSc != 4'hF) mSc++;
      if (res && mBr != 4'hF) mBr++;
      if (res && tk && mTk != 4'hF) mTk++;
    end
    reqCount++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t ev, ov;
    rst = 1'b1;
    set_br(1, 1, 0, 5'd3, 5'd0, 1); set_ex(1, 0, 5'd3); set_mem(0, 0, 5'd0);
    @(posedge clk); #1;
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    rst = 1'b0;
    expect_cycle(1, 0, 0, 2'b00, 2'b00);
    set_ex(0, 0, 5'd0); set_mem(1, 0, 5'd3);
    expect_cycle(0, 1, 1, 2'b01, 2'b00);
    set_br(0, 0, 0, 5'd0, 5'd0, 0); set_mem(0, 0, 5'd0);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    while (expQ.size() > 0) begin
      ev = expQ.pop_front(); checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL reset: no sample, required %h", ev);
      else begin
        ov = obsQ.pop_front();
        if (ov !== ev) $display("[TB] FAIL reset: got %h required %h", ov, ev);
        else passCount++;
      end
    end
  endtask

  task automatic test_no_hazard();
    snap_t ev, ov;
    set_ex(0, 0, 5'd0); set_mem(0, 0, 5'd0);
    set_br(1, 1, 0, 5'd1, 5'd2, 1); expect_cycle(0, 1, 1, 2'b00, 2'b00);
    set_br(1, 0, 1, 5'd1, 5'd2, 1); expect_cycle(0, 1, 0, 2'b00, 2'b00);
    set_br(1, 0, 1, 5'd1, 5'd2, 0); expect_cycle(0, 1, 1, 2'b00, 2'b00);
    set_br(1, 1, 0, 5'd1, 5'd2, 0); expect_cycle(0, 1, 0, 2'b00, 2'b00);
    set_br(1, 0, 0, 5'd3, 5'd3, 1); set_ex(1, 0, 5'd3);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    set_br(0, 1, 0, 5'd6, 5'd7, 1); set_ex(0, 0, 5'd0); set_mem(1, 1, 5'd6);
    expect_cycle(0, 0, 0, 2'b10, 2'b00);
    set_br(1, 1, 0, 5'd6, 5'd7, 0); set_mem(1, 0, 5'd7);
    expect_cycle(0, 1, 0, 2'b00, 2'b01);
    set_br(0, 0, 0, 5'd0, 5'd0, 0); set_mem(0, 0, 5'd0);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    while (expQ.size() > 0) begin
      ev = expQ.pop_front(); checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL no_hazard: no sample, required %h", ev);
      else begin
        ov = obsQ.pop_front();
        if (ov !== ev) $display("[TB] FAIL no_hazard: got %h required %h", ov, ev);
        else passCount++;
      end
    end
  endtask

  task automatic test_alu_raw();
    snap_t ev, ov;
    set_ex(1, 0, 5'd3); set_mem(0, 0, 5'd0); set_br(1, 1, 0, 5'd3, 5'd0, 1);
    expect_cycle(1, 0, 0, 2'b00, 2'b00);
    set_ex(0, 0, 5'd0); set_mem(1, 0, 5'd3);
    expect_cycle(0, 1, 1, 2'b01, 2'b00);
    // EX write to $8 shadows an older MEM write to $8
    set_ex(1, 1, 5'd8); set_mem(1, 0, 5'd8); set_br(1, 0, 1, 5'd2, 5'd8, 0);
    expect_cycle(1, 0, 0, 2'b00, 2'b00);
    set_ex(0, 0, 5'd0); set_mem(1, 1, 5'd8);
    expect_cycle(0, 1, 1, 2'b00, 2'b10);
    set_br(0, 0, 0, 5'd0, 5'd0, 0); set_mem(0, 0, 5'd0);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    while (expQ.size() > 0) begin
      ev = expQ.pop_front(); checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL alu_raw: no sample, required %h", ev);
      else begin
        ov = obsQ.pop_front();
        if (ov !== ev) $display("[TB] FAIL alu_raw: got %h required %h", ov, ev);
        else passCount++;
      end
    end
  endtask

  task automatic test_load_use();
    snap_t ev, ov;
    set_ex(1, 1, 5'd4); set_mem(0, 0, 5'd0); set_br(1, 0, 1, 5'd5, 5'd4, 0);
    expect_cycle(1, 0, 0, 2'b00, 2'b00);
    set_ex(0, 0, 5'd0); set_mem(1, 1, 5'd4);
    expect_cycle(0, 1, 1, 2'b00, 2'b10);
    set_ex(1, 1, 5'd4); set_mem(0, 0, 5'd0); set_br(1, 1, 0, 5'd4, 5'd4, 1);
    expect_cycle(1, 0, 0, 2'b00, 2'b00);
    set_ex(0, 0, 5'd0); set_mem(1, 1, 5'd4);
    expect_cycle(0, 1, 1, 2'b10, 2'b10);
    set_br(0, 0, 0, 5'd0, 5'd0, 0); set_mem(0, 0, 5'd0);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    while (expQ.size() > 0) begin
      ev = expQ.pop_front(); checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL load_use: no sample, required %h", ev);
      else begin
        ov = obsQ.pop_front();
        if (ov !== ev) $display("[TB] FAIL load_use: got %h required %h", ov, ev);
        else passCount++;
      end
    end
  endtask

  task automatic test_reg_zero();
    snap_t ev, ov;
    set_ex(1, 1, 5'd0); set_mem(1, 0, 5'd0); set_br(1, 1, 0, 5'd0, 5'd0, 1);
    expect_cycle(0, 1, 1, 2'b00, 2'b00);
    set_br(0, 0, 0, 5'd0, 5'd0, 0); set_ex(0, 0, 5'd0); set_mem(0, 0, 5'd0);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    while (expQ.size() > 0) begin
      ev = expQ.pop_front(); checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL reg_zero: no sample, required %h", ev);
      else begin
        ov = obsQ.pop_front();
        if (ov !== ev) $display("[TB] FAIL reg_zero: got %h required %h", ov, ev);
        else passCount++;
      end
    end
  endtask

  task automatic test_abort();
    snap_t ev, ov;
    set_ex(1, 0, 5'd9); set_mem(0, 0, 5'd0); set_br(1, 1, 0, 5'd9, 5'd1, 1);
    expect_cycle(1, 0, 0, 2'b00, 2'b00);
    set_br(0, 1, 0, 5'd9, 5'd1, 1);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    set_br(0, 0, 0, 5'd0, 5'd0, 0); set_ex(0, 0, 5'd0);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    // reset while stalled
    set_ex(1, 0, 5'd9); set_br(1, 1, 0, 5'd9, 5'd1, 1);
    expect_cycle(1, 0, 0, 2'b00, 2'b00);
    rst = 1'b1;
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    rst = 1'b0; set_ex(0, 0, 5'd0); set_br(0, 0, 0, 5'd0, 5'd0, 0);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    set_br(1, 1, 0, 5'd1, 5'd2, 1);
    expect_cycle(0, 1, 1, 2'b00, 2'b00);
    while (expQ.size() > 0) begin
      ev = expQ.pop_front(); checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL abort: no sample, required %h", ev);
      else begin
        ov = obsQ.pop_front();
        if (ov !== ev) $display("[TB] FAIL abort: got %h required %h", ov, ev);
        else passCount++;
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_t ev, ov;
    set_ex(0, 0, 5'd0); set_mem(0, 0, 5'd0);
    set_br(1, 0, 1, 5'd1, 5'd2, 0); expect_cycle(0, 1, 1, 2'b00, 2'b00);
    set_br(1, 1, 0, 5'd1, 5'd2, 0); expect_cycle(0, 1, 0, 2'b00, 2'b00);
    set_ex(1, 0, 5'd2); set_br(1, 1, 0, 5'd1, 5'd2, 1);
    expect_cycle(1, 0, 0, 2'b00, 2'b00);
    set_ex(0, 0, 5'd0); set_mem(1, 0, 5'd2);
    expect_cycle(0, 1, 1, 2'b00, 2'b01);
    set_br(0, 0, 0, 5'd0, 5'd0, 0); set_mem(0, 0, 5'd0);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    while (expQ.size() > 0) begin
      ev = expQ.pop_front(); checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL back_to_back: no sample, required %h", ev);
      else begin
        ov = obsQ.pop_front();
        if (ov !== ev) $display("[TB] FAIL back_to_back: got %h required %h", ov, ev);
        else passCount++;
      end
    end
  endtask

  task automatic test_saturation();
    snap_t ev, ov;
    set_ex(0, 0, 5'd0); set_mem(0, 0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      set_br(1, 1, 0, 5'd1, 5'd2, 1);
      expect_cycle(0, 1, 1, 2'b00, 2'b00);
    end
    set_br(0, 0, 0, 5'd0, 5'd0, 0);
    expect_cycle(0, 0, 0, 2'b00, 2'b00);
    while (expQ.size() > 0) begin
      ev = expQ.pop_front(); checkCount++;
      if (obsQ.size() == 0) $display("[TB] FAIL saturation: no sample, required %h", ev);
      else begin
        ov = obsQ.pop_front();
        if (ov !== ev) $display("[TB] FAIL saturation: got %h required %h", ov, ev);
        else passCount++;
      end
    end
    checkCount++;
    if ({br_cnt, taken_cnt} !== 8'hFF)
      $display("[TB] FAIL sat_hold: br/taken got %h/%h required f/f", br_cnt, taken_cnt);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_no_hazard();
    test_alu_raw();
    test_load_use();
    test_reg_zero();
    test_abort();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
